// File: rtl/des_key_schedule.sv
// DES key-schedule generator. Produces one 48-bit round key per accepted handshake.
// Keys come out in encrypt order (K1..K16) or decrypt order (K16..K1). C/D rotations
// and PC-2 are computed on the fly from the registered C/D halves, so no table of
// round keys is stored.
//
// Ports:
//   clk                clock, rising edge
//   rst_n              asynchronous active-low reset
//   start_i            load key_i/decrypt_i and begin a schedule (only taken in IDLE)
//   key_i[63:0]        DES key with parity bits, DES bit 1 = key_i[63]
//   decrypt_i          0 = K1 first, 1 = K16 first
//   round_key_o[47:0]  current round key (PC-2 output), DES bit 1 = [47]
//   round_key_valid_o  round_key_o is valid
//   round_key_ready_i  consumer accepts the current key
//   round_idx_o[3:0]   presentation index 0..15
//   busy_o             schedule in progress
//   done_o             one-cycle pulse after the last key is accepted
module des_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic [47:0] round_key_o,
    output logic        round_key_valid_o,
    input  logic        round_key_ready_i,
    output logic [3:0]  round_idx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS - 1);

    // PC-1: output bit n (1..56) takes DES key bit PC1_TAB[n-1].
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: output bit n (1..48) takes C/D bit PC2_TAB[n-1].
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES numbers bits from 1 at the MSB, so bit n of a W-bit vector sits at [W-n].
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] out;
        out = '0;
        for (int i = 0; i < 56; i++) begin
            out[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        end
        return out;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] out;
        out = '0;
        for (int i = 0; i < 48; i++) begin
            out[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return out;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    logic [0:0]  state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;

    logic [55:0] pc1_key;
    logic        shift_two;

    assign pc1_key = pc1(key_i);

    // Leaving presentation index 0, 7 or 14 the step is a single-bit shift in both
    // directions (encrypt keys 2/9/16, decrypt presentations 2/9/16); otherwise two.
    assign shift_two = !((idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14));

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    dec_d   = decrypt_i;
                    idx_d   = 4'd0;
                    state_d = StRun;
                    // Decrypt starts from K16, whose C/D equals the PC-1 value
                    // because the total rotation over 16 rounds is 28.
                    if (decrypt_i) begin
                        c_d = pc1_key[55:28];
                        d_d = pc1_key[27:0];
                    end else begin
                        c_d = rotl(pc1_key[55:28], 1'b0);
                        d_d = rotl(pc1_key[27:0], 1'b0);
                    end
                end
            end
            StRun: begin
                if (round_key_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (dec_q) begin
                            c_d = rotr(c_q, shift_two);
                            d_d = rotr(d_q, shift_two);
                        end else begin
                            c_d = rotl(c_q, shift_two);
                            d_d = rotl(d_q, shift_two);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    // Key output is forced to zero outside RUN so stale C/D never leaks out.
    assign round_key_o       = (state_q == StRun) ? pc2({c_q, d_q}) : 48'h0;
    assign round_key_valid_o = (state_q == StRun);
    assign busy_o            = (state_q == StRun);
    assign round_idx_o       = idx_q;
    assign done_o            = done_q;

endmodule
